// File: rtl/camera_capture_packer_if.sv
// Sensor capture bus plus FIFO write port of the camera capture packer.
// master = packer side (samples the sensor, drives the FIFO write strobe).
interface camera_capture_packer_if;
  logic        vsync;
  logic        href;
  logic [7:0]  camData;
  logic        fifoFull;
  logic        fifoPush;
  logic [17:0] fifoData;

  modport master (
    input  vsync, href, camData, fifoFull,
    output fifoPush, fifoData
  );

  modport slave (
    output vsync, href, camData, fifoFull,
    input  fifoPush, fifoData
  );
endinterface

// File: rtl/camera_capture_packer.sv
// PCLK-domain front end: packs sensor byte pairs into {sof, eol, rgb565} words for the pixel FIFO.
// A pixel is pushed two cycles after its low byte is on camData; fifoFull at completion drops the frame.
module camera_capture_packer #(
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  camera_capture_packer_if.master cam,
  output logic [COUNT_WIDTH-1:0]  frameCount,
  output logic                    overflow,
  output logic                    lineError,
  output logic                    busy
);

  localparam int COL_W  = $clog2(LINE_PIXELS + 1);
  localparam int LINE_W = $clog2(FRAME_LINES + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  state_t                 state_q, state_d;
  logic                   vsync_r_q, vsync_r2_q, href_r_q, href_r2_q;
  logic [7:0]             data_r_q;
  logic                   phase_q, phase_d;
  logic [7:0]             high_q, high_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [LINE_W-1:0]      line_q, line_d;
  logic                   sof_pend_q, sof_pend_d;
  logic                   push_q, push_d;
  logic [17:0]            data_q, data_d;
  logic [COUNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   lerr_q, lerr_d;

  logic vs_rise, vs_fall, href_fall, line_ok;

  assign vs_rise   = vsync_r_q & ~vsync_r2_q;
  assign vs_fall   = ~vsync_r_q & vsync_r2_q;
  assign href_fall = ~href_r_q & href_r2_q;
  // Lines past FRAME_LINES are ignored entirely; the line counter saturates there.
  assign line_ok   = line_q < LINE_W'(FRAME_LINES);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    high_d      = high_q;
    col_d       = col_q;
    line_d      = line_q;
    sof_pend_d  = sof_pend_q;
    push_d      = 1'b0;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    ovf_d       = ovf_q;
    lerr_d      = lerr_q;

    case (state_q)
      IDLE: begin
        if (vs_fall && enable) begin
          state_d    = ACTIVE;
          phase_d    = 1'b0;
          col_d      = '0;
          line_d     = '0;
          sof_pend_d = 1'b1;
        end
      end
      ACTIVE: begin
        // A vsync edge wins over any line activity in the same cycle.
        if (vs_rise) begin
          state_d = IDLE;
          if (line_q != '0) frame_cnt_d = frame_cnt_q + COUNT_WIDTH'(1);
          if (href_r_q && line_ok) lerr_d = 1'b1;
        end else if (href_r_q) begin
          if (line_ok) begin
            if (!phase_q) begin
              high_d  = data_r_q;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (col_q == COL_W'(LINE_PIXELS)) begin
                lerr_d = 1'b1;
              end else if (cam.fifoFull) begin
                ovf_d   = 1'b1;
                state_d = DROP;
              end else begin
                push_d     = 1'b1;
                data_d     = {sof_pend_q, col_q == COL_W'(LINE_PIXELS - 1), high_q, data_r_q};
                sof_pend_d = 1'b0;
                col_d      = col_q + COL_W'(1);
              end
            end
          end
        end else if (href_fall) begin
          if (line_ok) begin
            if (col_q != COL_W'(LINE_PIXELS) || phase_q) lerr_d = 1'b1;
            line_d = line_q + LINE_W'(1);
          end
          phase_d = 1'b0;
          col_d   = '0;
        end
      end
      DROP: begin
        if (vs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      vsync_r_q   <= 1'b0;
      vsync_r2_q  <= 1'b0;
      href_r_q    <= 1'b0;
      href_r2_q   <= 1'b0;
      data_r_q    <= '0;
      phase_q     <= 1'b0;
      high_q      <= '0;
      col_q       <= '0;
      line_q      <= '0;
      sof_pend_q  <= 1'b0;
      push_q      <= 1'b0;
      data_q      <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      lerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_r_q   <= cam.vsync;
      vsync_r2_q  <= vsync_r_q;
      href_r_q    <= cam.href;
      href_r2_q   <= href_r_q;
      data_r_q    <= cam.camData;
      phase_q     <= phase_d;
      high_q      <= high_d;
      col_q       <= col_d;
      line_q      <= line_d;
      sof_pend_q  <= sof_pend_d;
      push_q      <= push_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      lerr_q      <= lerr_d;
    end
  end

  assign cam.fifoPush = push_q;
  assign cam.fifoData = data_q;
  assign frameCount   = frame_cnt_q;
  assign overflow     = ovf_q;
  assign lineError    = lerr_q;
  assign busy         = (state_q != IDLE);

endmodule
